dec_gpr_wb_arb: RTL
===================

// Module: dec_gpr_wb_arb
// PURPOSE
//  Writeback arbiter driving the three GPR write ports (wen0..2/waddr0..2/wd0..2) and the bank-select
//  port (wen_bank_id/wr_bank_id) of the decode-stage GPR file. Accepts writeback requests from N_SRC
//  producers (i0/i1 pipes, load return, divider) via valid/ready handshakes. Grants up to 3 per cycle
//  with distinct target GPRs and registers the result for one cycle. Sequences bank switches so no
//  write straddles a bank change.
// PARAMETERS
//  N_SRC           4   number of writeback sources, 3..8; index 0 is highest priority (oldest)
//  GPR_BANKS_LOG2  1   width of the GPR bank id
// PORTS
//  clk          in   1          core clock
//  rst          in   1          synchronous reset, active-high
//  src_valid    in   N_SRC      per-source writeback request
//  src_addr     in   N_SRC x5   per-source target GPR
//  src_data     in   N_SRC x64  per-source write data
//  src_ready    out  N_SRC      accept; transfer occurs when src_valid & src_ready
//  bank_req     in   1          level request to switch GPR bank; held until bank_done
//  bank_id      in   GPR_BANKS_LOG2  target bank, stable while bank_req=1
//  bank_busy    out  1          switch in progress (DRAIN or SWITCH state)
//  bank_done    out  1          one-cycle pulse: switch complete
//  wen0/1/2     out  1          GPR write enables (registered)
//  waddr0/1/2   out  5          GPR write addresses (registered)
//  wd0/1/2      out  64         GPR write data (registered)
//  wen_bank_id  out  1          one-cycle bank-id write strobe
//  wr_bank_id   out  GPR_BANKS_LOG2  bank id written on wen_bank_id
// BEHAVIOUR
//  Reset: all outputs 0 (src_ready=0, wen*=0, waddr*=0, wd*=0, bank_*=0, wr_bank_id=0); FSM=IDLE.
//  Grant (combinational, IDLE only): scan sources 0..N_SRC-1; grant src i if valid and its addr differs
//   from every earlier granted nonzero addr and fewer than 3 nonzero grants taken. src_ready = grant.
//  addr==0: always granted in IDLE, consumes no port, never drives wen (x0 discard).
//  Same-addr collision in one cycle: lowest index wins, loser ready=0 and retries next cycle.
//  Port fill: nonzero grants in ascending source index -> port 0, 1, 2; unused ports wen=0.
//  Latency: accepted in cycle N -> wen/waddr/wd asserted in cycle N+1, deasserted N+2 unless regranted.
//  Invariant: never two asserted wen with equal waddr in a cycle; never wen with waddr==0.
//  FSM IDLE->DRAIN when bank_req=1 (sampled): from that cycle src_ready=0 for all sources.
//  DRAIN->SWITCH when no wen asserted this cycle (output register empty); same cycle if already empty.
//  SWITCH: wen_bank_id=1, wr_bank_id=bank_id for exactly one cycle; bank_done=1 same cycle ->IDLE.
//  IDLE blocks re-entry to DRAIN for one cycle after SWITCH (requester must drop bank_req on bank_done).
//  bank_busy = (state!=IDLE).
//  bank_req and src_valid same cycle: bank_req wins, no grant that cycle.
//  rst mid-DRAIN/SWITCH: FSM->IDLE, pending register writes cancelled (wen cleared), no bank strobe.
// CONFIGURATION
//  GPR_WB_PERF_EN defined: adds output conflict_cnt [31:0]; increments (saturating at 32'hFFFF_FFFF)
//   each cycle >=1 valid source is denied in IDLE (collision or >3 requests); reset to 0.
//  Undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  src0 x5=0x11, src1 x6=0x22 same cycle -> next cycle wen0=1 waddr0=5 wd0=0x11, wen1=1 waddr1=6, wen2=0.
//  src0,src2 both x7 (0xA,0xB) -> cycle1 wen0 x7=0xA, src2 ready=0; cycle2 wen0 x7=0xB.
//  4 valid, distinct x1..x4 -> src0..2 granted to ports 0..2, src3 next cycle on port 0; perf cnt=1.
//  src1 addr=0, src0 x9 -> both ready=1; only wen0 (x9) asserted; wen1=wen2=0.
//  writes in flight + bank_req, bank_id=1 -> ready=0, wen drains, then wen_bank_id=1 wr_bank_id=1 and
//   bank_done=1 for one cycle, next grant only after IDLE.
//  rst asserted in DRAIN with wen0 pending -> next cycle all outputs 0, no wen_bank_id ever pulsed.

Source files
------------

// File: rtl/dec_gpr_wb_arb.sv
// dec_gpr_wb_arb: writeback arbiter for the decode-stage GPR file.
// Grants up to three distinct nonzero target GPRs per cycle from N_SRC
// producers (index 0 = highest priority) onto registered write ports 0..2,
// and sequences GPR bank switches (IDLE -> DRAIN -> SWITCH -> IDLE) so that
// no register write straddles a bank change.
// Optional feature: define GPR_WB_PERF_EN to add the conflict_cnt output.
module dec_gpr_wb_arb #(
   parameter int unsigned N_SRC          = 4,
   parameter int unsigned GPR_BANKS_LOG2 = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [N_SRC-1:0]                src_valid,
   input  logic [N_SRC-1:0][4:0]           src_addr,
   input  logic [N_SRC-1:0][63:0]          src_data,
   output logic [N_SRC-1:0]                src_ready,
   input  logic                            bank_req,
   input  logic [GPR_BANKS_LOG2-1:0]       bank_id,
   output logic                            bank_busy,
   output logic                            bank_done,
   output logic                            wen0,
   output logic                            wen1,
   output logic                            wen2,
   output logic [4:0]                      waddr0,
   output logic [4:0]                      waddr1,
   output logic [4:0]                      waddr2,
   output logic [63:0]                     wd0,
   output logic [63:0]                     wd1,
   output logic [63:0]                     wd2,
   output logic                            wen_bank_id,
   output logic [GPR_BANKS_LOG2-1:0]       wr_bank_id
`ifdef GPR_WB_PERF_EN
   ,
   output logic [31:0]                     conflict_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_SWITCH
   } state_t;

   state_t           state;
   logic             sw_block;   // one-cycle lockout after SWITCH
   logic             grant_en;
   logic [N_SRC-1:0] grant;
   logic             hit;
   logic [1:0]       n_take;
   logic [2:0]       p_wen;
   logic [2:0][4:0]  p_addr;
   logic [2:0][63:0] p_data;
   logic [2:0]       wen_r;
   logic [2:0][4:0]  waddr_r;
   logic [2:0][63:0] wd_r;

   // Grants are only issued in IDLE; a pending bank request wins over writeback.
   assign grant_en = ~rst & (state == ST_IDLE) & ~(bank_req & ~sw_block);

   // Priority scan: x0 always accepted (discarded), others need a free port and a unique address.
   always_comb begin
      grant  = '0;
      p_wen  = '0;
      p_addr = '0;
      p_data = '0;
      n_take = '0;
      hit    = 1'b0;
      if (grant_en) begin
         for (int unsigned i = 0; i < N_SRC; i++) begin
            if (src_valid[i]) begin
               if (src_addr[i] == 5'd0) begin
                  grant[i] = 1'b1;
               end else begin
                  hit = 1'b0;
                  for (int unsigned k = 0; k < 3; k++) begin
                     if (p_wen[k] && (p_addr[k] == src_addr[i])) hit = 1'b1;
                  end
                  if (!hit && (n_take != 2'd3)) begin
                     grant[i]       = 1'b1;
                     p_wen[n_take]  = 1'b1;
                     p_addr[n_take] = src_addr[i];
                     p_data[n_take] = src_data[i];
                     n_take         = n_take + 2'd1;
                  end
               end
            end
         end
      end
   end

   assign src_ready = grant;

   // Write-port register and bank-switch FSM with registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         sw_block    <= 1'b0;
         wen_r       <= '0;
         waddr_r     <= '0;
         wd_r        <= '0;
         bank_busy   <= 1'b0;
         bank_done   <= 1'b0;
         wen_bank_id <= 1'b0;
         wr_bank_id  <= '0;
      end else begin
         wen_r       <= p_wen;
         waddr_r     <= p_addr;
         wd_r        <= p_data;
         bank_done   <= 1'b0;
         wen_bank_id <= 1'b0;
         wr_bank_id  <= '0;
         sw_block    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bank_req && !sw_block) begin
                  state     <= ST_DRAIN;
                  bank_busy <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (wen_r == '0) begin
                  state       <= ST_SWITCH;
                  wen_bank_id <= 1'b1;
                  wr_bank_id  <= bank_id;
                  bank_done   <= 1'b1;
               end
            end
            ST_SWITCH: begin
               state     <= ST_IDLE;
               bank_busy <= 1'b0;
               sw_block  <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               bank_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef GPR_WB_PERF_EN
   logic denied;
   assign denied = grant_en & |(src_valid & ~grant);

   // Saturating count of IDLE cycles where at least one valid source was refused.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (denied && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif

   assign wen0   = wen_r[0];
   assign wen1   = wen_r[1];
   assign wen2   = wen_r[2];
   assign waddr0 = waddr_r[0];
   assign waddr1 = waddr_r[1];
   assign waddr2 = waddr_r[2];
   assign wd0    = wd_r[0];
   assign wd1    = wd_r[1];
   assign wd2    = wd_r[2];

endmodule
